// File: rtl/gen_rr_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gen_sched_pkg                                                |
// | Description : Shared definitions for the round-robin generator scheduler:  |
// |               default sizing, scheduler state encoding and the response    |
// |               beat record.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package gen_sched_pkg;

    localparam int c_num_req_def = 4;
    localparam int c_data_w_def  = 32;
    localparam int c_id_w_def    = $clog2(c_num_req_def);
    localparam int c_timeout_def = 1024;

    // Scheduler states
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_clear  = 3'd1;
    localparam state_t c_st_launch = 3'd2;
    localparam state_t c_st_stream = 3'd3;
    localparam state_t c_st_drain  = 3'd4;

    // One response beat at the default sizing
    typedef struct packed {
        logic [c_data_w_def-1:0] data;
        logic [c_id_w_def-1:0]   id;
        logic                    last;
        logic                    err;
    } rsp_beat_t;

endpackage
`default_nettype wire

// File: rtl/gen_rr_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gen_rr_scheduler_if                                          |
// | Description : Bundles the requester, generator-core and response ports of  |
// |               the scheduler.                                               |
// |   req_valid/req_arg/req_ready : per-requester job request and accept       |
// |   gen_rst/gen_start/gen_n/gen_ready : control towards the generator core   |
// |   gen_valid/gen_done/gen_out  : result stream from the generator core      |
// |   rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_last/rsp_err : tagged responses  |
// |   modport master : scheduler side; modport slave : surrounding logic side  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface gen_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_arg;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      gen_rst;
    logic                      gen_start;
    logic [DATA_W-1:0]         gen_n;
    logic                      gen_ready;
    logic                      gen_valid;
    logic                      gen_done;
    logic [DATA_W-1:0]         gen_out;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_last;
    logic                      rsp_err;

    modport master (
        input  req_valid, req_arg, gen_valid, gen_done, gen_out, rsp_ready,
        output req_ready, gen_rst, gen_start, gen_n, gen_ready,
               rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
    );

    modport slave (
        output req_valid, req_arg, gen_valid, gen_done, gen_out, rsp_ready,
        input  req_ready, gen_rst, gen_start, gen_n, gen_ready,
               rsp_valid, rsp_data, rsp_id, rsp_last, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/gen_rr_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin pick: grants the first set request |
// |               bit at or after the pointer, wrapping around.                |
// |   i_req   : request vector                                                 |
// |   i_ptr   : highest-priority position                                      |
// |   o_grant : one-hot grant                                                  |
// |   o_idx   : index of the granted bit                                       |
// |   o_any   : at least one request present                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? (s - N) : s;
    endfunction

    logic [IDX_W-1:0] w_pos;

    // Scan from the furthest offset back to the pointer so the closest
    // requester overwrites any earlier match.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = IDX_W'(wrap_idx(int'(i_ptr), k));
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
                o_any          = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gen_rr_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gen_rr_scheduler                                             |
// | Description : Shares one generator core among NUM_REQ requesters in        |
// |               round-robin order. Per job it grants a requester, resets and |
// |               launches the core, then forwards the core stream through a   |
// |               one-entry tagged response register ending in a last beat.    |
// |   clock : rising-edge clock                                                |
// |   reset : asynchronous active-low reset                                    |
// |   bus   : gen_rr_scheduler_if.master (requests, core control, responses)   |
// | Option      : GEN_RR_SCHEDULER_TIMEOUT_EN adds a stall watchdog that ends  |
// |               the job with rsp_err after TIMEOUT idle core cycles.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gen_rr_scheduler
    import gen_sched_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_def,
    parameter int DATA_W  = c_data_w_def,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = c_timeout_def
) (
    input  logic               clock,
    input  logic               reset,
    gen_rr_scheduler_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_arg;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any;
    logic               w_accept;
    logic               w_gen_ready;
    logic               w_beat;
    logic               w_timeout;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_last;
    logic              r_rsp_err;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    // The core may only advance when the response register is free or
    // being emptied this cycle.
    assign w_gen_ready = (r_state == c_st_stream) & (~r_rsp_valid | bus.rsp_ready);
    assign w_beat      = w_gen_ready & bus.gen_valid;

`ifdef GEN_RR_SCHEDULER_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [c_cnt_w-1:0] r_stall_cnt;

    // Counts only cycles where we offer ready and the core stays silent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state != c_st_stream) || w_beat) begin
            r_stall_cnt <= '0;
        end else if (w_gen_ready) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_timeout = w_gen_ready & ~bus.gen_valid & (r_stall_cnt == c_cnt_w'(TIMEOUT - 1));
`else
    // Watchdog compiled out: the expression is constant false.
    assign w_timeout = 1'b0 & (TIMEOUT != 0);
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_clear;
                end
            end
            c_st_clear:  w_state_nxt = c_st_launch;
            c_st_launch: w_state_nxt = c_st_stream;
            c_st_stream: begin
                if ((w_beat & bus.gen_done) | w_timeout) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Job context and response register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_arg       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_arg    <= bus.req_arg[int'(w_grant_idx) * DATA_W +: DATA_W];
                r_id     <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end

            if (w_beat) begin
                // The terminal core beat carries no payload of ours; it only
                // turns into the zero-data last beat.
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_err   <= 1'b0;
                if (bus.gen_done) begin
                    r_rsp_data <= '0;
                    r_rsp_last <= 1'b1;
                end else begin
                    r_rsp_data <= bus.gen_out;
                    r_rsp_last <= 1'b0;
                end
            end else if (w_timeout) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_data  <= '0;
                r_rsp_last  <= 1'b1;
                r_rsp_err   <= 1'b1;
            end else if (r_rsp_valid & bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_last  <= 1'b0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    // Accept is gated by reset so no grant leaks out while held in reset.
    assign bus.req_ready = (w_accept & reset) ? w_grant : '0;
    assign bus.gen_rst   = ~reset | (r_state == c_st_clear);
    assign bus.gen_start = (r_state == c_st_launch);
    assign bus.gen_n     = r_arg;
    assign bus.gen_ready = w_gen_ready;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
